// File: rtl/muldiv_if.sv
// Request/response bundle between the execute-stage pipeline and the RV32M multiply/divide unit.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, kill,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Op encoding (alu_operation_type): MUL=8, MULH=9, DIV=12, DIVU=13, REM=14, REMU=15; other codes are ALU ops.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic      clk,
    input logic      rst,
    muldiv_if.slave  bus
);
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REM  = 4'd14;
    localparam logic [3:0] OP_REMU = 4'd15;
    localparam int         CW      = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_mul, is_div, is_rem, is_signed, is_mop, accept;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              q_mul;
    logic [XLEN:0]     mul_sum, div_trial, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    always_comb begin
        is_mul    = (bus.op == OP_MUL) || (bus.op == OP_MULH);
        is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        is_rem    = (bus.op == OP_REM) || (bus.op == OP_REMU);
        is_mop    = is_mul || is_div || is_rem;
        is_signed = is_mul || (bus.op == OP_DIV) || (bus.op == OP_REM);
        neg_a     = is_signed && bus.a[XLEN-1];
        neg_b     = is_signed && bus.b[XLEN-1];
        mag_a     = neg_a ? -bus.a : bus.a;
        mag_b     = neg_b ? -bus.b : bus.b;
        accept    = bus.start && !bus.kill && is_mop &&
                    ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Multiply keeps the multiplier in the low half and shifts the partial sum in from the top;
    // divide keeps remainder:quotient and shifts the dividend out of the low half.
    always_comb begin
        q_mul     = (op_q == OP_MUL) || (op_q == OP_MULH);
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
        div_trial = acc_q[2*XLEN-1:XLEN-1];
        div_ge    = div_trial >= {1'b0, opnd_q};
        div_diff  = div_trial - {1'b0, opnd_q};
        prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix   = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix   = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        if (bus.kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (accept) begin
                        op_d    = bus.op;
                        sa_d    = neg_a;
                        sb_d    = neg_b;
                        cnt_d   = '0;
                        state_d = S_CALC;
                        if (is_mul) begin
                            opnd_d = mag_a;
                            acc_d  = {{XLEN{1'b0}}, mag_b};
                        end else begin
                            opnd_d = mag_b;
                            acc_d  = {{XLEN{1'b0}}, mag_a};
                        end
                        if (!is_mul && (bus.b == '0)) begin
                            result_d = is_div ? {XLEN{1'b1}} : bus.a;
                            state_d  = S_DONE;
                        end else if (((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                                     (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == {XLEN{1'b1}})) begin
                            result_d = (bus.op == OP_DIV) ? bus.a : '0;
                            state_d  = S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    if (q_mul) begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end else if (div_ge) begin
                        acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
                end
                S_FIX: begin
                    case (op_q)
                        OP_MUL:           result_d = prod_fix[XLEN-1:0];
                        OP_MULH:          result_d = prod_fix[2*XLEN-1:XLEN];
                        OP_DIV, OP_DIVU:  result_d = quo_fix;
                        default:          result_d = rem_fix;
                    endcase
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed results and latencies.
module tb_muldiv_unit;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REM  = 4'd14;
    localparam logic [3:0] OP_REMU = 4'd15;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    muldiv_if mif ();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(mif));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble the operand inputs after accept, and measure latency/busy span.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int bcnt;
        mif.start = 1'b1;
        mif.op    = op;
        mif.a     = a;
        mif.b     = b;
        step();
        mif.start = 1'b0;
        mif.op    = OP_ADD;
        mif.a     = 32'hDEAD_BEEF;
        mif.b     = 32'h0001_2345;
        lat  = 1;
        bcnt = 0;
        while (!mif.done && lat < 100) begin
            if (mif.busy) bcnt++;
            step();
            lat++;
        end
        chk({tag, "_done"}, 64'(mif.done), 64'd1);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, 64'(mif.result), 64'(exp));
        chk({tag, "_busycyc"}, 64'(bcnt), 64'(exp_lat - 1));
        chk({tag, "_busy_at_done"}, 64'(mif.busy), 64'd0);
        step();
        chk({tag, "_pulse"}, 64'(mif.done), 64'd0);
    endtask

    initial begin
        int lat;
        int seen_done;
        int seen_busy;

        rst = 1'b1;
        mif.start = 1'b0;
        mif.op    = OP_ADD;
        mif.a     = '0;
        mif.b     = '0;
        mif.kill  = 1'b0;
        repeat (3) step();
        chk("reset_busy", 64'(mif.busy), 64'd0);
        chk("reset_done", 64'(mif.done), 64'd0);
        chk("reset_result", 64'(mif.result), 64'd0);
        rst = 1'b0;
        step();

        run_op("mul_7xm3",   OP_MUL,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulh_min2",  OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        run_op("divu_big",   OP_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 34);
        run_op("remu_big",   OP_REMU, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 34);
        run_op("div_by0",    OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_by0",    OP_REM,  32'd5,         32'd0,         32'd5,         1);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Back-to-back: start stays high, second op accepted in the first op's DONE cycle.
        mif.start = 1'b1;
        mif.op    = OP_MUL;
        mif.a     = 32'd3;
        mif.b     = 32'd4;
        step();
        mif.op = OP_DIVU;
        mif.a  = 32'd100;
        mif.b  = 32'd7;
        lat = 1;
        while (!mif.done && lat < 100) begin
            step();
            lat++;
        end
        chk("b2b_first_lat", 64'(lat), 64'd34);
        chk("b2b_first_result", 64'(mif.result), 64'd12);
        step();
        chk("b2b_second_busy", 64'(mif.busy), 64'd1);
        lat = 1;
        while (!mif.done && lat < 100) begin
            step();
            lat++;
        end
        mif.start = 1'b0;
        chk("b2b_gap", 64'(lat), 64'd34);
        chk("b2b_second_result", 64'(mif.result), 64'd14);
        step();
        chk("b2b_pulse", 64'(mif.done), 64'd0);

        // Kill at CALC iteration 10 of DIV 100/3.
        mif.start = 1'b1;
        mif.op    = OP_DIV;
        mif.a     = 32'd100;
        mif.b     = 32'd3;
        step();
        mif.start = 1'b0;
        repeat (10) step();
        chk("kill_busy_before", 64'(mif.busy), 64'd1);
        mif.kill = 1'b1;
        step();
        mif.kill = 1'b0;
        chk("kill_busy_after", 64'(mif.busy), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (mif.done) seen_done++;
            step();
        end
        chk("kill_no_done", 64'(seen_done), 64'd0);
        chk("kill_result_kept", 64'(mif.result), 64'd14);
        run_op("div_100_3", OP_DIV, 32'd100, 32'd3, 32'd33, 34);

        // Reset mid-CALC, then a non-M op must be ignored.
        mif.start = 1'b1;
        mif.op    = OP_MUL;
        mif.a     = 32'd3;
        mif.b     = 32'd4;
        step();
        mif.start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_busy", 64'(mif.busy), 64'd0);
        chk("rst_mid_done", 64'(mif.done), 64'd0);
        chk("rst_mid_result", 64'(mif.result), 64'd0);
        mif.start = 1'b1;
        mif.op    = OP_ADD;
        mif.a     = 32'd1;
        mif.b     = 32'd2;
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 2) mif.start = 1'b0;
            if (mif.done) seen_done++;
            if (mif.busy) seen_busy++;
        end
        chk("add_no_busy", 64'(seen_busy), 64'd0);
        chk("add_no_done", 64'(seen_done), 64'd0);
        chk("add_result", 64'(mif.result), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the RV32M operations. It sits in the execute stage directly downstream of `alu_ctrl`. When `alu_ctrl` decodes an `OP` instruction with `funct7 = 7'b0000001` into `MUL`, `MULH`, `DIV`, `DIVU`, `REM` or `REMU`, the pipeline hands this unit the operands and stalls on `busy`. The unit returns one XLEN-bit result with a single-cycle `done` pulse. All non-M operations stay in the single-cycle ALU.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  alu_operation_type (common)  operation from `alu_ctrl`; only the six M ops are legal with `start`.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- kill  in  1  pipeline flush; aborts any operation in flight.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse; `result` is valid in that cycle.
- result  out  XLEN  result; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset forces IDLE, `busy=0`, `done=0`, `result=0`, all internal registers 0.
- Accept: `start=1`, state IDLE or DONE, `kill=0`, op is one of the six M ops.
  - On accept, latch op, sign flags and magnitudes (abs for `MUL`/`MULH`/`DIV`/`REM`, raw for `DIVU`/`REMU`), clear the iteration counter, go to CALC.
  - `start` with a non-M op is ignored: state unchanged, no `done`.
- Special cases are detected at accept and go straight to DONE with `result` loaded:
  - Divide by zero (`b=0`): `DIV`/`DIVU` give all ones; `REM`/`REMU` give `a`.
  - Signed overflow (`a=0x80000000`, `b=0xFFFFFFFF`): `DIV` gives `0x80000000`; `REM` gives 0.
- CALC runs one iteration per cycle for exactly XLEN cycles; counter 0..XLEN-1, then FIX.
  - Multiply: shift-add on magnitudes into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract giving quotient and remainder magnitudes.
- FIX applies sign correction:
  - Product negated if `sign(a)^sign(b)`.
  - Quotient negated if signs differ (signed ops only).
  - Remainder takes the sign of `a` (signed ops only).
  - Result selection: `MUL` = product[XLEN-1:0]; `MULH` = product[2XLEN-1:XLEN], signed×signed; `DIV`/`DIVU` = quotient; `REM`/`REMU` = remainder.
  - Go to DONE.
- DONE: `done=1` for this cycle only. Next state is CALC (or DONE for a special case) on a new accept, otherwise IDLE.
- `kill=1` in any state returns to IDLE at the next edge. No `done` is produced, `result` is unchanged, and a simultaneous `start` is ignored.
- `rst` has priority over `kill`, which has priority over `start`.
- Operand inputs may change freely after accept; only latched copies are used.

## Timing
- Accept edge T, normal path:
  - State is CALC after edge T and FIX after edge T+XLEN.
  - State is DONE after edge T+XLEN+1, so `done` is high in the cycle after edge T+XLEN+1. Latency is XLEN+2 = 34 cycles.
- Accept edge T, special case: `done` is high in the cycle after edge T. Latency is 1.
- `busy` rises in the cycle after edge T and falls when DONE is entered. `busy` and `done` are never high together.
- Back-to-back: `start` held high in the DONE cycle is accepted, so throughput is one op per XLEN+2 cycles.
- Reset mid-operation: the state after the reset edge is IDLE with all outputs 0, and no `done` is produced.

## Test plan
- Reset, then `MUL` with a=7, b=0xFFFFFFFD. Then `MULH` with a=b=0x80000000.
  - `MUL` -> `result=0xFFFFFFEB`, `done` 34 cycles after accept, `busy` high for cycles 1–33.
  - `MULH` -> `0x40000000`.
- `DIV` a=0xFFFFFFF9 (-7), b=2 -> `0xFFFFFFFD`. `REM` same operands -> `0xFFFFFFFF`. `DIVU` a=0xFFFFFFFF, b=0x10 -> `0x0FFFFFFF`. `REMU` same -> `0xF`.
- Divide by zero and overflow, each with `done` 1 cycle after accept and `busy` never high:
  - `DIV` 5/0 -> `0xFFFFFFFF`; `REM` 5/0 -> 5.
  - `DIV` 0x80000000/0xFFFFFFFF -> `0x80000000`; `REM` -> 0.
- Back-to-back: `start` held high with `MUL` 3×4 then `DIVU` 100/7.
  - Second op accepted in the DONE cycle of the first.
  - Results 12 then 14; `done` pulses 34 cycles apart.
- `kill` asserted at CALC iteration 10 of `DIV` 100/3 -> IDLE next cycle, no `done`, `result` keeps its prior value. A fresh `DIV` 100/3 then gives 33.
- `rst` asserted mid-CALC -> outputs 0, IDLE. `start` with op=`ADD` -> ignored, `busy` stays 0, no `done`.
